// File: rtl/uart_rx.sv
// uart_rx
//
// 8N1 serial receiver with a single-entry valid/ready output buffer.
// The line is resynchronised, the start bit is checked at its middle, and
// every data and stop bit is sampled at its centre.
//
// Ports:
//   clk            block clock; all logic on its rising edge
//   rst            asynchronous active-low reset
//   uart_rxd       asynchronous serial input, idles high, LSB first
//   uart_rd_data   received byte, valid while uart_rd_valid is high
//   uart_rd_valid  a received byte is being offered
//   uart_rd_ready  consumer accepts the offered byte
//   frame_err      one-cycle pulse: stop bit sampled low
//   overrun        one-cycle pulse: a byte was dropped because the buffer was full
module uart_rx #(
   parameter int CLK_FREQ  = 100000000,
   parameter int BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rxd,
   output logic [7:0] uart_rd_data,
   output logic       uart_rd_valid,
   input  logic       uart_rd_ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int DIV   = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
   localparam int HALF  = DIV / 2;
   localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

   localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

   generate
      if (DIV < 4) begin : g_div_check
         $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t           state_q, state_d;
   logic             rxd_meta_q, rxd_meta_d;
   logic             rxd_s_q, rxd_s_d;
   logic [1:0]       sync_fill_q, sync_fill_d;
   logic             armed_q, armed_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;
   logic             deliver;
   logic             tick;

   // Next-state logic for the synchronizer, bit-timing FSM and output buffer.
   // sync_fill marks when rxd_s carries real line data rather than its reset
   // value; armed only sets once the line has genuinely been seen high, so a
   // line still low after reset routes through WAIT_IDLE instead of being
   // mistaken for a start bit.
   always_comb begin
      state_d     = state_q;
      rxd_meta_d  = uart_rxd;
      rxd_s_d     = rxd_meta_q;
      sync_fill_d = {sync_fill_q[0], 1'b1};
      armed_d     = armed_q | (sync_fill_q[1] & rxd_s_q);
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = rd_valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      deliver     = 1'b0;
      tick        = (cnt_q == '0);

      case (state_q)
         IDLE: begin
            if (!rxd_s_q) begin
               if (armed_q) begin
                  state_d = START;
                  cnt_d   = HALF_M1;
               end else begin
                  state_d = WAIT_IDLE;
               end
            end
         end
         START: begin
            if (tick) begin
               if (rxd_s_q) begin
                  state_d = IDLE;
               end else begin
                  state_d   = DATA;
                  cnt_d     = DIV_M1;
                  bit_idx_d = 3'd0;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DATA: begin
            if (tick) begin
               shift_d = {rxd_s_q, shift_q[7:1]};
               cnt_d   = DIV_M1;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         STOP: begin
            if (tick) begin
               if (rxd_s_q) begin
                  deliver = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         WAIT_IDLE: begin
            if (rxd_s_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A delivery may replace the held byte only if it is leaving this cycle.
      if (deliver) begin
         if (!rd_valid_q || uart_rd_ready) begin
            rd_data_d  = shift_q;
            rd_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (rd_valid_q && uart_rd_ready) begin
         rd_valid_d = 1'b0;
      end
   end

   // All state registers; reset abandons any frame and any held byte.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         rxd_meta_q  <= 1'b1;
         rxd_s_q     <= 1'b1;
         sync_fill_q <= 2'b00;
         armed_q     <= 1'b0;
         cnt_q       <= '0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         rd_data_q   <= 8'h00;
         rd_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rxd_meta_q  <= rxd_meta_d;
         rxd_s_q     <= rxd_s_d;
         sync_fill_q <= sync_fill_d;
         armed_q     <= armed_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign uart_rd_data  = rd_data_q;
   assign uart_rd_valid = rd_valid_q;
   assign frame_err     = frame_err_q;
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
//
// Directed bench for uart_rx at 100 MHz / 115200 baud: a behavioural serial
// driver on uart_rxd, and a monitor on the rd handshake that logs transferred
// bytes, valid rising edges, frame_err and overrun pulses.
module tb_uart_rx;

   localparam int DIV  = 868;
   localparam int HALF = 434;
   localparam int LAT  = HALF + 9 * DIV + 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       uart_rxd = 1'b1;
   logic       uart_rd_ready = 1'b1;
   logic [7:0] uart_rd_data;
   logic       uart_rd_valid;
   logic       frame_err;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_rx #(
      .CLK_FREQ (100000000),
      .BAUD_RATE(115200)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .uart_rxd     (uart_rxd),
      .uart_rd_data (uart_rd_data),
      .uart_rd_valid(uart_rd_valid),
      .uart_rd_ready(uart_rd_ready),
      .frame_err    (frame_err),
      .overrun      (overrun)
   );

   // Handshake monitor, sampling 1 time unit after each falling edge.
   logic [7:0] xfer_q[$];
   int         valid_rises = 0;
   int         fe_total = 0;
   int         ov_total = 0;
   logic       prev_valid = 1'b0;
   longint     t_rise = 0;
   longint     t_fall = 0;

   always begin
      @(negedge clk);
      #1;
      if (uart_rd_valid && uart_rd_ready) xfer_q.push_back(uart_rd_data);
      if (uart_rd_valid && !prev_valid) begin
         valid_rises++;
         t_rise = $time;
      end
      prev_valid = uart_rd_valid;
      if (frame_err) fe_total++;
      if (overrun) ov_total++;
   end

   task automatic idle(input int n);
      uart_rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic v);
      uart_rxd = v;
      repeat (DIV) @(negedge clk);
   endtask

   task automatic send_bits(input logic [7:0] b);
      t_fall = $time;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
   endtask

   // Stop bit is held past its sample point; callers extend it when needed.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      send_bits(b);
      uart_rxd = stop;
      repeat (HALF + 20) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      idle(5);
      checks++;
      if (uart_rd_data !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_data got %h want 00", uart_rd_data);
      end
      checks++;
      if (uart_rd_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_valid got %b want 0", uart_rd_valid);
      end
      checks++;
      if (frame_err !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_pulses got fe=%b ov=%b want 0 0", frame_err, overrun);
      end
      rst = 1'b1;
      idle(20);
   endtask

   task automatic test_single_byte;
      int n0, v0, f0, o0;
      longint lat;
      n0 = xfer_q.size(); v0 = valid_rises; f0 = fe_total; o0 = ov_total;
      uart_rd_ready = 1'b1;
      send_frame(8'h48, 1'b1);
      idle(20);
      checks++;
      if (valid_rises - v0 != 1) begin
         errors++;
         $display("[TB] FAIL single_valid_count got %0d want 1", valid_rises - v0);
      end
      checks++;
      if (xfer_q.size() - n0 != 1 || xfer_q[n0] !== 8'h48) begin
         errors++;
         $display("[TB] FAIL single_data got n=%0d want n=1 data=48", xfer_q.size() - n0);
      end
      lat = (t_rise - t_fall) / 10;
      checks++;
      if (lat < LAT - 1 || lat > LAT + 1) begin
         errors++;
         $display("[TB] FAIL single_latency got %0d want %0d", lat, LAT);
      end
      checks++;
      if (fe_total != f0 || ov_total != o0) begin
         errors++;
         $display("[TB] FAIL single_pulses got fe=%0d ov=%0d want 0 0", fe_total - f0, ov_total - o0);
      end
      checks++;
      if (uart_rd_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_valid_drop got %b want 0", uart_rd_valid);
      end
   endtask

   task automatic test_glitch;
      int n0, v0, f0;
      n0 = xfer_q.size(); v0 = valid_rises; f0 = fe_total;
      uart_rxd = 1'b0;
      repeat (200) @(negedge clk);
      idle(300);
      checks++;
      if (xfer_q.size() != n0 || valid_rises != v0 || fe_total != f0) begin
         errors++;
         $display("[TB] FAIL glitch_quiet got xfers=%0d rises=%0d fe=%0d want 0 0 0",
                  xfer_q.size() - n0, valid_rises - v0, fe_total - f0);
      end
      send_frame(8'h47, 1'b1);
      idle(20);
      checks++;
      if (xfer_q.size() - n0 != 1 || xfer_q[n0] !== 8'h47) begin
         errors++;
         $display("[TB] FAIL glitch_next_frame got n=%0d want n=1 data=47", xfer_q.size() - n0);
      end
   endtask

   task automatic test_frame_error;
      int n0, v0, f0;
      n0 = xfer_q.size(); v0 = valid_rises; f0 = fe_total;
      send_frame(8'h55, 1'b0);
      repeat (3 * DIV) @(negedge clk);
      checks++;
      if (fe_total - f0 != 1) begin
         errors++;
         $display("[TB] FAIL ferr_pulse got %0d want 1", fe_total - f0);
      end
      checks++;
      if (xfer_q.size() != n0 || valid_rises != v0) begin
         errors++;
         $display("[TB] FAIL ferr_no_valid got xfers=%0d rises=%0d want 0 0",
                  xfer_q.size() - n0, valid_rises - v0);
      end
      idle(100);
      send_frame(8'hA3, 1'b1);
      idle(20);
      checks++;
      if (xfer_q.size() - n0 != 1 || xfer_q[n0] !== 8'hA3) begin
         errors++;
         $display("[TB] FAIL ferr_recover got n=%0d want n=1 data=A3", xfer_q.size() - n0);
      end
   endtask

   task automatic test_overrun;
      int n0, v0, o0;
      n0 = xfer_q.size(); v0 = valid_rises; o0 = ov_total;
      uart_rd_ready = 1'b0;
      send_frame(8'h48, 1'b1);
      idle(DIV - HALF - 20);
      send_frame(8'h47, 1'b1);
      idle(20);
      checks++;
      if (ov_total - o0 != 1) begin
         errors++;
         $display("[TB] FAIL overrun_pulse got %0d want 1", ov_total - o0);
      end
      checks++;
      if (uart_rd_valid !== 1'b1 || uart_rd_data !== 8'h48) begin
         errors++;
         $display("[TB] FAIL overrun_hold got valid=%b data=%h want 1 48", uart_rd_valid, uart_rd_data);
      end
      uart_rd_ready = 1'b1;
      idle(5);
      checks++;
      if (xfer_q.size() - n0 != 1 || xfer_q[n0] !== 8'h48) begin
         errors++;
         $display("[TB] FAIL overrun_transfer got n=%0d want n=1 data=48", xfer_q.size() - n0);
      end
      checks++;
      if (uart_rd_valid !== 1'b0 || valid_rises - v0 != 1) begin
         errors++;
         $display("[TB] FAIL overrun_drain got valid=%b rises=%0d want 0 1", uart_rd_valid, valid_rises - v0);
      end
   endtask

   // Ready rises exactly on the cycle whose edge delivers 0xFF, so the held
   // 0x00 leaves as 0xFF loads and valid never drops in between.
   task automatic test_back_to_back;
      int n0, v0, o0;
      n0 = xfer_q.size(); v0 = valid_rises; o0 = ov_total;
      uart_rd_ready = 1'b0;
      send_frame(8'h00, 1'b1);
      idle(20);
      send_bits(8'hFF);
      uart_rxd = 1'b1;
      repeat (HALF + 2) @(negedge clk);
      uart_rd_ready = 1'b1;
      idle(20);
      checks++;
      if (ov_total != o0) begin
         errors++;
         $display("[TB] FAIL b2b_overrun got %0d want 0", ov_total - o0);
      end
      checks++;
      if (xfer_q.size() - n0 != 2 || xfer_q[n0] !== 8'h00 || xfer_q[n0+1] !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL b2b_data got n=%0d want n=2 data=00,FF", xfer_q.size() - n0);
      end
      checks++;
      if (valid_rises - v0 != 1 || uart_rd_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_valid got rises=%0d valid=%b want 1 0", valid_rises - v0, uart_rd_valid);
      end
   endtask

   task automatic test_reset_mid_frame;
      int n0, v0;
      logic [7:0] b;
      b = 8'h12;
      n0 = xfer_q.size(); v0 = valid_rises;
      uart_rd_ready = 1'b1;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(b[i]);
      rst = 1'b0;
      idle(10);
      checks++;
      if (uart_rd_valid !== 1'b0 || uart_rd_data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_outputs got valid=%b data=%h fe=%b ov=%b want 0 00 0 0",
                  uart_rd_valid, uart_rd_data, frame_err, overrun);
      end
      rst = 1'b1;
      idle(2 * DIV);
      checks++;
      if (xfer_q.size() != n0 || valid_rises != v0) begin
         errors++;
         $display("[TB] FAIL midrst_spurious got xfers=%0d rises=%0d want 0 0",
                  xfer_q.size() - n0, valid_rises - v0);
      end
      send_frame(8'h34, 1'b1);
      idle(20);
      checks++;
      if (xfer_q.size() - n0 != 1 || xfer_q[n0] !== 8'h34) begin
         errors++;
         $display("[TB] FAIL midrst_next_frame got n=%0d want n=1 data=34", xfer_q.size() - n0);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_byte();
      test_glitch();
      test_frame_error();
      test_overrun();
      test_back_to_back();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-003 Port clk  in  1  single block clock; all logic is on its rising edge.
REQ-004 Port rst  in  1  reset, asynchronous and active-low: asserts at any time, releases synchronously to clk.
REQ-005 Port uart_rxd  in  1  asynchronous serial line; idles high; 8N1 frames, LSB first.
REQ-006 Port uart_rd_data  out  8  received byte; valid while uart_rd_valid=1.
REQ-007 Port uart_rd_valid  out  1  received byte available.
REQ-008 Port uart_rd_ready  in  1  consumer accepts the byte.
REQ-009 Port frame_err  out  1  one-cycle pulse: stop bit sampled low.
REQ-010 Port overrun  out  1  one-cycle pulse: a byte completed while the output buffer was full and not being drained.

Function
REQ-011 uart_rxd SHALL pass through a 2-flop synchronizer (rxd_s) before any use; the synchronizer resets to 1.
REQ-012 Bit period DIV SHALL be round(CLK_FREQ/BAUD_RATE), which is 868 at the defaults; HALF SHALL be DIV/2 truncated, which is 434.
REQ-013 The counter SHALL be wide enough for DIV-1 at elaboration; the design SHALL reject DIV<4 with an elaboration error.
REQ-014 The FSM states SHALL be IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-015 IDLE: when rxd_s=0, the FSM SHALL load the counter and move to START.
REQ-016 START: after HALF cycles the FSM SHALL sample rxd_s. If 1, the frame is a glitch: return to IDLE with no output. If 0, move to DATA.
REQ-017 DATA: every DIV cycles the FSM SHALL sample rxd_s into the shift register, LSB first. After the 8th sample it SHALL move to STOP.
REQ-018 STOP: after DIV cycles the FSM SHALL sample rxd_s. If 1, deliver the byte (REQ-020) and go to IDLE. If 0, pulse frame_err, discard the byte and go to WAIT_IDLE.
REQ-019 WAIT_IDLE: the FSM SHALL stay until rxd_s=1, then go to IDLE. This covers break conditions, and no new start bit is detected until the line returns high.
REQ-020 Delivery: uart_rd_data and uart_rd_valid SHALL update on the clock after the stop-bit sample.
REQ-021 Output buffer is single-entry: uart_rd_valid stays high and uart_rd_data stays stable until a cycle with uart_rd_valid=1 and uart_rd_ready=1.
REQ-022 Handshake transfer occurs on that cycle. uart_rd_valid SHALL deassert on the next clock unless a new byte is delivered on the same cycle.
REQ-023 Simultaneous delivery and transfer: the new byte SHALL load and uart_rd_valid SHALL stay 1.
REQ-024 Delivery while valid=1 and ready=0: overrun SHALL pulse, the new byte SHALL be dropped and the held byte SHALL be unchanged.
REQ-025 uart_rd_valid SHALL NOT depend combinationally on uart_rd_ready; all outputs SHALL be registered.
REQ-026 The receiver SHALL never stall the line: FSM progress SHALL be independent of uart_rd_ready.
REQ-027 Latency: the 0 to 1 transition of uart_rd_valid SHALL occur HALF+9*DIV+3 cycles (±1) after the uart_rxd falling edge.

Reset
REQ-028 While rst=0: FSM=IDLE, counter=0, shift register=0, uart_rd_data=0x00, uart_rd_valid=0, frame_err=0, overrun=0, synchronizer=1.
REQ-029 Reset mid-frame SHALL abandon the frame with no output.
REQ-030 After release, a line that is still low SHALL be treated as a start bit only after it has been seen high (entry via WAIT_IDLE).
REQ-031 Reset SHALL drop any held, unread byte.

Verification
REQ-032 Bench on 100 MHz clk at 115200 baud, with a behavioural serial driver on uart_rxd and a checker on the rd handshake.
REQ-033 Frame 0x48 with ready=1 -> one valid cycle with data=0x48, timed per REQ-027; frame_err=0, overrun=0.
REQ-034 Low pulse of 200 cycles on idle line -> no valid and no frame_err; the FSM returns to IDLE; a following frame 0x47 is received correctly.
REQ-035 Frame 0x55 with stop bit driven 0, line held low 3 bit-times -> frame_err pulses once, no valid. The line then rises and a 0xA3 frame yields data=0xA3.
REQ-036 Frames 0x48 then 0x47 back-to-back with ready=0 -> valid=1, data=0x48 held; overrun pulses once at 0x47 delivery. Raising ready gives one transfer of 0x48, after which valid=0.
REQ-037 Ready held high and valid asserted in the same cycle as the next delivery -> both 0x00 and 0xFF are transferred, with no overrun.
REQ-038 rst=0 in the middle of DATA of frame 0x12, then released with the line high -> outputs at reset values and no spurious byte; the next frame 0x34 is received correctly.
